sync_fifo_fwft: RTL and testbench

- Single-clock, parametrised FIFO that succeeds the dual-clock FIFO used across the game datapath (sprite/coin event queues, UART/command buffering).
- Adds the following on top of the basic full/empty FIFO:
  - selectable read mode: registered or first-word-fall-through (FWFT);
  - fill-level count;
  - programmable almost-full and almost-empty flags;
  - synchronous flush;
  - sticky overflow and underflow error flags.

---
 rtl/sync_fifo_fwft.sv | 73 +++++++
 tb/tb_sync_fifo_fwft.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with registered or first-word-fall-through read, level flags and sticky errors
module sync_fifo_fwft #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_wren,
    input  logic [WIDTH-1:0]         i_wrdata,
    input  logic                     i_rden,
    output logic [WIDTH-1:0]         o_rddata,
    output logic                     o_rdvalid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    input  logic                     i_clr_err,
    output logic                     o_overflow,
    output logic                     o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE = (AW+1)'(AE_LEVEL);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wrptr, rdptr, count;
    logic wr_acc, rd_acc;
    assign o_empty        = wrptr == rdptr;
    assign o_full         = (wrptr[AW] != rdptr[AW]) && (wrptr[AW-1:0] == rdptr[AW-1:0]);
    assign o_almost_full  = count >= AF;
    assign o_almost_empty = count <= AE;
    assign o_count        = count;
    // flush suppresses both the operations and any error they would raise
    assign wr_acc = i_wren & ~o_full & ~i_flush;
    assign rd_acc = i_rden & ~o_empty & ~i_flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr       <= '0;
            rdptr       <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            wrptr       <= i_flush ? '0 : wrptr + (AW+1)'(wr_acc);
            rdptr       <= i_flush ? '0 : rdptr + (AW+1)'(rd_acc);
            count       <= i_flush ? '0 : count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
            o_overflow  <= (o_overflow & ~i_clr_err) | (i_wren & o_full & ~i_flush);
            o_underflow <= (o_underflow & ~i_clr_err) | (i_rden & o_empty & ~i_flush);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wrptr[AW-1:0]] <= i_wrdata;
    end
    if (FWFT != 0) begin : g_fwft
        assign o_rddata  = mem[rdptr[AW-1:0]];
        assign o_rdvalid = ~o_empty;
    end else begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                o_rddata  <= '0;
                o_rdvalid <= 1'b0;
            end else begin
                o_rddata  <= rd_acc ? mem[rdptr[AW-1:0]] : o_rddata;
                o_rdvalid <= rd_acc;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: drives a registered-read and an FWFT instance in lockstep against a queue scoreboard
module tb_sync_fifo_fwft;
    logic clk, rst_n, flush, wren, rden, clr_err;
    logic [7:0] wrdata;
    logic [7:0] d0_rddata, d1_rddata;
    logic d0_rdvalid, d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un;
    logic d1_rdvalid, d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un;
    logic [4:0] d0_count, d1_count;
    int total = 0, bad = 0;
    logic [7:0] q[$];
    logic [7:0] m_last;
    logic m_vld, m_ov, m_un;

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .o_rddata(d0_rddata), .o_rdvalid(d0_rdvalid), .o_full(d0_full), .o_empty(d0_empty),
        .o_almost_full(d0_af), .o_almost_empty(d0_ae), .o_count(d0_count), .i_clr_err(clr_err),
        .o_overflow(d0_ov), .o_underflow(d0_un));
    sync_fifo_fwft #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .o_rddata(d1_rddata), .o_rdvalid(d1_rdvalid), .o_full(d1_full), .o_empty(d1_empty),
        .o_almost_full(d1_af), .o_almost_empty(d1_ae), .o_count(d1_count), .i_clr_err(clr_err),
        .o_overflow(d1_ov), .o_underflow(d1_un));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".cnt0"}, 32'(d0_count), n);
        chk({tag, ".cnt1"}, 32'(d1_count), n);
        chk({tag, ".full"}, {d1_full, d0_full}, {2{n == 16}});
        chk({tag, ".empty"}, {d1_empty, d0_empty}, {2{n == 0}});
        chk({tag, ".af"}, {d1_af, d0_af}, {2{n >= 14}});
        chk({tag, ".ae"}, {d1_ae, d0_ae}, {2{n <= 2}});
        chk({tag, ".ov"}, {d1_ov, d0_ov}, {2{m_ov}});
        chk({tag, ".un"}, {d1_un, d0_un}, {2{m_un}});
        chk({tag, ".vld0"}, 32'(d0_rdvalid), 32'(m_vld));
        chk({tag, ".dat0"}, 32'(d0_rddata), 32'(m_last));
        chk({tag, ".vld1"}, 32'(d1_rdvalid), 32'(n != 0));
        if (n != 0)
            chk({tag, ".dat1"}, 32'(d1_rddata), 32'(q[0]));
    endtask

    task automatic cyc(input string tag, input logic wr, input logic [7:0] d, input logic rd,
                       input logic fl = 1'b0, input logic ce = 1'b0);
        logic full, empty, wa, ra;
        wren = wr; wrdata = d; rden = rd; flush = fl; clr_err = ce;
        full  = q.size() == 16;
        empty = q.size() == 0;
        wa = wr & ~full & ~fl;
        ra = rd & ~empty & ~fl;
        m_ov = (m_ov & ~ce) | (wr & full & ~fl);
        m_un = (m_un & ~ce) | (rd & empty & ~fl);
        m_vld = ra;
        if (ra) m_last = q.pop_front();
        if (wa) q.push_back(d);
        if (fl) q.delete();
        @(posedge clk);
        #1;
        wren = 1'b0; rden = 1'b0; flush = 1'b0; clr_err = 1'b0;
        chk_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0; m_vld = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wren = 1'b0; rden = 1'b0; clr_err = 1'b0; wrdata = '0;
        model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0);
        cyc("ovf", 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 8'h00, 1'b1);
        cyc("unf", 1'b0, 8'h00, 1'b1);
        cyc("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("pre5", 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) cyc("simul", 1'b1, 8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 11; i++) cyc("tofull", 1'b1, 8'(8'h60 + i), 1'b0);
        cyc("simfull", 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 15; i++) cyc("drain2", 1'b0, 8'h00, 1'b1);
        cyc("simempty", 1'b1, 8'h99, 1'b1);
        cyc("clr2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc("fwft3c", 1'b1, 8'h3C, 1'b0);
        cyc("fwft5a", 1'b1, 8'h5A, 1'b0);
        cyc("fwftpop", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) begin
            logic w, r;
            w = (q.size() < 15) && ($urandom_range(0, 1) == 1);
            r = (q.size() > 1) && ($urandom_range(0, 1) == 1);
            cyc("rand", w, 8'($urandom), r);
        end
        while (q.size() < 9) cyc("to9", 1'b1, 8'($urandom), 1'b0);
        cyc("flush", 1'b1, 8'hEE, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc("to8", 1'b1, 8'(8'hB0 + i), 1'b0);
        cyc("to7", 1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc("post1", 1'b1, 8'hC3, 1'b0);
        cyc("post2", 1'b0, 8'h00, 1'b1);
        cyc("post3", 1'b0, 8'h00, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
